// File: rtl/circuit_1_arbiter.sv
// Two-client round-robin arbiter that sequences one shared circuit_1.
// Latches the winner's operands, holds them, samples out/out_bar, returns result.
module circuit_1_arbiter #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       d0,
  input  logic [2:0]       d1,
  input  logic             a0,
  input  logic             b0,
  input  logic             c0,
  input  logic             a1,
  input  logic             b1,
  input  logic             c1,
  input  logic             sel0,
  input  logic             sel1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             res0,
  output logic             res1,
  output logic [2:0]       cir_D,
  output logic             cir_A,
  output logic             cir_B,
  output logic             cir_C,
  output logic             cir_Sel,
  input  logic             cir_out,
  input  logic             cir_out_bar,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int HC_W =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST =
    HC_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             res0_q, res0_d;
  logic             res1_q, res1_d;
  logic [2:0]       cir_d_q, cir_d_d;
  logic             cir_a_q, cir_a_d;
  logic             cir_b_q, cir_b_d;
  logic             cir_c_q, cir_c_d;
  logic             cir_sel_q, cir_sel_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             win;

  // Next-state: arbitration in IDLE, hold/sample in DRIVE, pulse in RESP.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    res0_d    = res0_q;
    res1_d    = res1_q;
    cir_d_d   = cir_d_q;
    cir_a_d   = cir_a_q;
    cir_b_d   = cir_b_q;
    cir_c_d   = cir_c_q;
    cir_sel_d = cir_sel_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    win       = (req0 && req1) ? ~last_q : req1;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          cir_d_d   = win ? d1 : d0;
          cir_a_d   = win ? a1 : a0;
          cir_b_d   = win ? b1 : b0;
          cir_c_d   = win ? c1 : c0;
          cir_sel_d = win ? sel1 : sel0;
          gnt0_d    = ~win;
          gnt1_d    = win;
          last_d    = win;
          hold_d    = '0;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          if (last_q) begin
            res1_d  = cir_out;
            done1_d = 1'b1;
          end else begin
            res0_d  = cir_out;
            done0_d = 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cir_out == cir_out_bar) begin
            err_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      hold_q    <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      res0_q    <= 1'b0;
      res1_q    <= 1'b0;
      cir_d_q   <= '0;
      cir_a_q   <= 1'b0;
      cir_b_q   <= 1'b0;
      cir_c_q   <= 1'b0;
      cir_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
      cir_d_q   <= cir_d_d;
      cir_a_q   <= cir_a_d;
      cir_b_q   <= cir_b_d;
      cir_c_q   <= cir_c_d;
      cir_sel_q <= cir_sel_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign res0     = res0_q;
  assign res1     = res1_q;
  assign cir_D    = cir_d_q;
  assign cir_A    = cir_a_q;
  assign cir_B    = cir_b_q;
  assign cir_C    = cir_c_q;
  assign cir_Sel  = cir_sel_q;
  assign busy     = busy_q;
  assign op_count = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_circuit_1_arbiter.sv
// Directed bench for circuit_1_arbiter with a behavioural circuit_1.
// circuit_1 stand-in: Sel=0 -> |D, Sel=1 -> A&B&C.
module tb_circuit_1_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] d0, d1;
  logic       a0, b0, c0, a1, b1, c1;
  logic       sel0, sel1;
  logic       gnt0, gnt1, done0, done1;
  logic       res0, res1;
  logic [2:0] cir_D;
  logic       cir_A, cir_B, cir_C, cir_Sel;
  logic       cir_out, cir_out_bar;
  logic       busy, err;
  logic [1:0] op_count;
  logic       tie;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign cir_out     = cir_Sel ? (cir_A & cir_B & cir_C) : |cir_D;
  assign cir_out_bar = tie ? cir_out : ~cir_out;

  circuit_1_arbiter #(.HOLD_CYCLES(1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .d0(d0), .d1(d1),
    .a0(a0), .b0(b0), .c0(c0),
    .a1(a1), .b1(b1), .c1(c1),
    .sel0(sel0), .sel1(sel1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .res0(res0), .res1(res1),
    .cir_D(cir_D), .cir_A(cir_A), .cir_B(cir_B),
    .cir_C(cir_C), .cir_Sel(cir_Sel),
    .cir_out(cir_out), .cir_out_bar(cir_out_bar),
    .busy(busy), .op_count(op_count), .err(err)
  );

  function automatic logic [31:0] all_out();
    return {15'd0, gnt0, gnt1, done0, done1, res0, res1,
            cir_D, cir_A, cir_B, cir_C, cir_Sel,
            busy, op_count, err};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tie  = 1'b0;
    rst_n = 1'b0;
    {req0, req1, d0, d1, a0, b0, c0, a1, b1, c1, sel0, sel1} = '0;
    #1;
    chk("reset_async", all_out(), 32'd0);
    for (int i = 0; i < 3; i++) begin
      {req0, req1} = 2'($urandom);
      d0 = 3'($urandom); d1 = 3'($urandom);
      {a0, b0, c0, a1, b1, c1, sel0, sel1} = 8'($urandom);
      cyc();
      chk("reset_rand", all_out(), 32'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // client 0, D=100, Sel=0 -> 1
    req0 = 1'b1; d0 = 3'b100; sel0 = 1'b0;
    cyc();
    chk("t2_gnt0", 32'({gnt0, gnt1}), 32'b10);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_cirD", 32'(cir_D), 32'b100);
    req0 = 1'b0;
    cyc();
    chk("t2_done", 32'({done0, done1, gnt0}), 32'b100);
    chk("t2_res0", 32'(res0), 32'd1);
    chk("t2_cnt", 32'(op_count), 32'd1);
    cyc();
    chk("t2_idle", 32'({busy, done0, res0}), 32'b001);

    // client 1, Sel=1, A=1 B=0 C=0 -> 0
    req1 = 1'b1; sel1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    cyc();
    chk("t3a_gnt1", 32'({gnt0, gnt1}), 32'b01);
    req1 = 1'b0;
    cyc();
    chk("t3a_done", 32'({done0, done1}), 32'b01);
    chk("t3a_res1", 32'(res1), 32'd0);
    cyc();
    // client 1, D=011, Sel=0 -> 1
    req1 = 1'b1; d1 = 3'b011; sel1 = 1'b0;
    cyc();
    chk("t3b_gnt1", 32'({gnt0, gnt1}), 32'b01);
    chk("t3b_cir", 32'({cir_D, cir_Sel}), 32'b0110);
    req1 = 1'b0;
    cyc();
    chk("t3b_res1", 32'({done1, res1}), 32'b11);
    chk("t3b_cnt", 32'(op_count), 32'd3);
    cyc();

    // both held from reset: 0,1,0,1; cnt wraps at 4
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    d0 = 3'b100; sel0 = 1'b0;
    sel1 = 1'b1; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("t4_gnt%0d", k), 32'({gnt0, gnt1}),
          (k % 2 == 0) ? 32'b10 : 32'b01);
      cyc();
      chk($sformatf("t4_done%0d", k), 32'({done0, done1}),
          (k % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("t4_cnt%0d", k), 32'(op_count),
          32'((k + 1) % 4));
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      cyc();
      chk($sformatf("t4_idle%0d", k), 32'({busy, gnt0, gnt1}), 32'd0);
    end
    chk("t4_res", 32'({res0, res1}), 32'b10);

    // fifth op since reset -> count 1 with CNT_W=2
    req0 = 1'b1;
    cyc();
    req0 = 1'b0;
    cyc();
    chk("t7_cnt", 32'(op_count), 32'd1);
    chk("t7_err", 32'(err), 32'd0);
    cyc();

    // out_bar tied to out -> sticky err
    tie = 1'b1;
    req1 = 1'b1;
    cyc();
    req1 = 1'b0;
    cyc();
    chk("t5_err_set", 32'({done1, err}), 32'b11);
    cyc();
    tie = 1'b0;
    req0 = 1'b1;
    cyc();
    req0 = 1'b0;
    cyc();
    chk("t5_err_hold", 32'({done0, err}), 32'b11);
    cyc();
    chk("t5_err_idle", 32'(err), 32'd1);

    // reset mid-DRIVE
    req1 = 1'b1;
    cyc();
    chk("t6_drive", 32'({gnt1, busy}), 32'b11);
    req1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async0", all_out(), 32'd0);
    cyc();
    chk("t6_nodone", all_out(), 32'd0);
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    cyc();
    chk("t6_tie_gnt0", 32'({gnt0, gnt1}), 32'b10);
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    chk("t6_done0", 32'({done0, done1, res0}), 32'b101);
    chk("t6_cnt", 32'(op_count), 32'd1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
